// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the datapath-to-controller signals of the 5-stage core.
// The datapath side (master) supplies register addresses, write enables and
// stage control bits. The controller side (slave) returns the stall, flush and
// forwarding controls, plus the memory-timeout flag and the stall counter.
interface hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    // Decode and execute source registers
    logic [4:0]             register_file_RA1_D;
    logic [4:0]             register_file_RA2_D;
    logic [4:0]             register_file_RA1_E;
    logic [4:0]             register_file_RA2_E;
    // Destination register and write enable of each later stage
    logic [4:0]             register_file_WA_E;
    logic [4:0]             register_file_WA_M;
    logic [4:0]             register_file_WA_W;
    logic                   ctrl_register_file_WE_E;
    logic                   ctrl_register_file_WE_M;
    logic                   ctrl_register_file_WE_W;
    // Stage control bits
    logic                   ctrl_result_E;
    logic                   branch_taken_M;
    logic                   ctrl_data_memory_access_M;
    logic                   data_memory_ready;
    // Controller outputs
    logic                   stall_F;
    logic                   stall_D;
    logic                   stall_E;
    logic                   stall_M;
    logic                   flush_D;
    logic                   flush_E;
    logic                   flush_W;
    logic [1:0]             forward_A_E;
    logic [1:0]             forward_B_E;
    logic                   mem_timeout;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output register_file_RA1_D, register_file_RA2_D,
        output register_file_RA1_E, register_file_RA2_E,
        output register_file_WA_E, register_file_WA_M, register_file_WA_W,
        output ctrl_register_file_WE_E, ctrl_register_file_WE_M, ctrl_register_file_WE_W,
        output ctrl_result_E, branch_taken_M,
        output ctrl_data_memory_access_M, data_memory_ready,
        input  stall_F, stall_D, stall_E, stall_M,
        input  flush_D, flush_E, flush_W,
        input  forward_A_E, forward_B_E,
        input  mem_timeout, stall_count
    );

    modport slave (
        input  register_file_RA1_D, register_file_RA2_D,
        input  register_file_RA1_E, register_file_RA2_E,
        input  register_file_WA_E, register_file_WA_M, register_file_WA_W,
        input  ctrl_register_file_WE_E, ctrl_register_file_WE_M, ctrl_register_file_WE_W,
        input  ctrl_result_E, branch_taken_M,
        input  ctrl_data_memory_access_M, data_memory_ready,
        output stall_F, stall_D, stall_E, stall_M,
        output flush_D, flush_E, flush_W,
        output forward_A_E, forward_B_E,
        output mem_timeout, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central pipeline controller for the 5-stage RISC-V core.
// Generates the stall/flush enables for the pipeline registers, the execute
// operand forwarding selects, and sequences wait states on data-memory
// accesses, with a timeout that parks the core in ERROR until reset.
// Optional feature macro: HAZARD_FORWARDING_EN. When it is defined, operands
// are forwarded from M/W and only load-use hazards stall decode. When it is
// undefined, forwarding selects stay 00 and any RAW hazard on an E or M
// producer stalls decode until that producer reaches W.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int STALL_CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    // Last wait_cnt value that may still be followed by another wait state
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t                 state_reg, state_next;
    logic [7:0]             wait_cnt_reg, wait_cnt_next;
    logic                   mem_timeout_reg;
    logic [STALL_CNT_W-1:0] stall_count_reg;

    logic       mem_wait;
    logic       decode_stall;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] fwd_a, fwd_b;

    // True when a write to a non-zero register 'wa' produces source 'ra'.
    // The wa != 0 term keeps x0 from ever causing a stall or a forward.
    function automatic logic reg_match(input logic [4:0] ra,
                                       input logic [4:0] wa,
                                       input logic       we);
        return we && (wa != 5'd0) && (ra == wa);
    endfunction

    assign mem_wait = hz.ctrl_data_memory_access_M && !hz.data_memory_ready;

`ifdef HAZARD_FORWARDING_EN
    // Operand select: the younger M-stage result wins over the W-stage result
    function automatic logic [1:0] fwd_sel(input logic [4:0] ra);
        if (reg_match(ra, hz.register_file_WA_M, hz.ctrl_register_file_WE_M))
            return 2'b01;
        else if (reg_match(ra, hz.register_file_WA_W, hz.ctrl_register_file_WE_W))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Only a load in E cannot be forwarded in time for the instruction in D
    assign decode_stall = hz.ctrl_result_E &&
        (reg_match(hz.register_file_RA1_D, hz.register_file_WA_E, hz.ctrl_register_file_WE_E) ||
         reg_match(hz.register_file_RA2_D, hz.register_file_WA_E, hz.ctrl_register_file_WE_E));

    assign fwd_a = fwd_sel(hz.register_file_RA1_E);
    assign fwd_b = fwd_sel(hz.register_file_RA2_E);
`else
    // Without forwarding, any pending producer in E or M holds decode.
    // W-stage producers are safe because the register file writes early.
    assign decode_stall =
        reg_match(hz.register_file_RA1_D, hz.register_file_WA_E, hz.ctrl_register_file_WE_E) ||
        reg_match(hz.register_file_RA2_D, hz.register_file_WA_E, hz.ctrl_register_file_WE_E) ||
        reg_match(hz.register_file_RA1_D, hz.register_file_WA_M, hz.ctrl_register_file_WE_M) ||
        reg_match(hz.register_file_RA2_D, hz.register_file_WA_M, hz.ctrl_register_file_WE_M);

    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;

    // These inputs only matter for forwarding or load-use detection
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{hz.register_file_RA1_E, hz.register_file_RA2_E,
                                 hz.register_file_WA_W, hz.ctrl_register_file_WE_W,
                                 hz.ctrl_result_E};
`endif

    // Next state, wait counter and the prioritised stall/flush controls
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_w       = 1'b0;
        case (state_reg)
            ERROR: begin
                // Freeze the pipe and keep bubbling W until reset
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end
            default: begin
                if (mem_wait) begin
                    stall_f       = 1'b1;
                    stall_d       = 1'b1;
                    stall_e       = 1'b1;
                    stall_m       = 1'b1;
                    flush_w       = 1'b1;
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                    state_next    = (wait_cnt_reg == WAIT_LAST) ? ERROR : MEM_WAIT;
                end else begin
                    // Access done (or none pending): release the pipe this cycle
                    state_next    = RUN;
                    wait_cnt_next = 8'd0;
                    if (hz.branch_taken_M) begin
                        // The redirect squashes the instruction a load-use would hold
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (decode_stall) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
            end
        endcase
    end

    // State, wait counter, sticky timeout flag and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= 8'd0;
            mem_timeout_reg <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_next == ERROR)
                mem_timeout_reg <= 1'b1;
            if (stall_f && (stall_count_reg != {STALL_CNT_W{1'b1}}))
                stall_count_reg <= stall_count_reg + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign hz.stall_F     = stall_f;
    assign hz.stall_D     = stall_d;
    assign hz.stall_E     = stall_e;
    assign hz.stall_M     = stall_m;
    assign hz.flush_D     = flush_d;
    assign hz.flush_E     = flush_e;
    assign hz.flush_W     = flush_w;
    assign hz.forward_A_E = fwd_a;
    assign hz.forward_B_E = fwd_b;
    assign hz.mem_timeout = mem_timeout_reg;
    assign hz.stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. Each step drives one
// cycle of stimulus, pushes the expected controls, and pops/compares them
// before the next rising edge. Expectations follow HAZARD_FORWARDING_EN.
module tb_hazard_ctrl;

    localparam int CW = 16;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Control groups: {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MW   = 7'b1111001;

    typedef struct packed {
        logic [4:0] ra1_d, ra2_d, ra1_e, ra2_e, wa_e, wa_m, wa_w;
        logic       we_e, we_m, we_w, load_e, br, acc, rdy;
    } stim_t;

    typedef struct packed {
        logic [6:0]    ctl;
        logic [1:0]    fa, fb;
        logic          to;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [CW-1:0] exp_cnt = '0;
    exp_t  sb_q[$];
    string tag_q[$];

    hazard_ctrl_if #(.STALL_CNT_W(CW)) hif ();

    hazard_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
        end
    endtask

    task automatic apply(input stim_t s);
        hif.register_file_RA1_D       = s.ra1_d;
        hif.register_file_RA2_D       = s.ra2_d;
        hif.register_file_RA1_E       = s.ra1_e;
        hif.register_file_RA2_E       = s.ra2_e;
        hif.register_file_WA_E        = s.wa_e;
        hif.register_file_WA_M        = s.wa_m;
        hif.register_file_WA_W        = s.wa_w;
        hif.ctrl_register_file_WE_E   = s.we_e;
        hif.ctrl_register_file_WE_M   = s.we_m;
        hif.ctrl_register_file_WE_W   = s.we_w;
        hif.ctrl_result_E             = s.load_e;
        hif.branch_taken_M            = s.br;
        hif.ctrl_data_memory_access_M = s.acc;
        hif.data_memory_ready         = s.rdy;
    endtask

    task automatic push_exp(input string tag, input logic [6:0] ctl,
                            input logic [1:0] fa, input logic [1:0] fb, input logic to);
        exp_t e;
        e.ctl = ctl;
        e.fa  = fa;
        e.fb  = fb;
        e.to  = to;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        // A stall_F cycle shows up in the counter from the next cycle on
        if (ctl[6] && exp_cnt != {CW{1'b1}})
            exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic pop_check();
        exp_t  e;
        string tag;
        logic [6:0] ctl;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e   = sb_q.pop_front();
        tag = tag_q.pop_front();
        ctl = {hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M,
               hif.flush_D, hif.flush_E, hif.flush_W};
        $display("txn %-16s ctl=%b fa=%b fb=%b to=%b cnt=%0d", tag, ctl,
                 hif.forward_A_E, hif.forward_B_E, hif.mem_timeout, hif.stall_count);
        chk({tag, ".ctl"}, 32'(ctl), 32'(e.ctl));
        chk({tag, ".fwdA"}, 32'(hif.forward_A_E), 32'(e.fa));
        chk({tag, ".fwdB"}, 32'(hif.forward_B_E), 32'(e.fb));
        chk({tag, ".timeout"}, 32'(hif.mem_timeout), 32'(e.to));
        chk({tag, ".count"}, 32'(hif.stall_count), 32'(e.cnt));
    endtask

    // One pipeline cycle: drive after the rising edge, check at the falling edge
    task automatic step(input string tag, input stim_t s, input logic [6:0] ctl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic to);
        @(posedge clk);
        #1;
        apply(s);
        push_exp(tag, ctl, fa, fb, to);
        @(negedge clk);
        pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        s = '0;
        apply(s);
        repeat (2) @(negedge clk);
        #1;
        push_exp("reset", C_NONE, 2'b00, 2'b00, 1'b0);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;

        s = '0;
        step("idle", s, C_NONE, 2'b00, 2'b00, 1'b0);

        s = '0; s.ra1_e = 5; s.wa_m = 5; s.we_m = 1; s.wa_w = 5; s.we_w = 1;
        step("fwd_m_over_w", s, C_NONE, FWD ? 2'b01 : 2'b00, 2'b00, 1'b0);
        s.wa_m = 6;
        step("fwd_w", s, C_NONE, FWD ? 2'b10 : 2'b00, 2'b00, 1'b0);
        s.ra1_e = 0;
        step("fwd_x0", s, C_NONE, 2'b00, 2'b00, 1'b0);

        s = '0; s.ra2_e = 5; s.wa_m = 5; s.we_m = 1;
        step("fwd_b_m", s, C_NONE, 2'b00, FWD ? 2'b01 : 2'b00, 1'b0);

        s = '0; s.load_e = 1; s.we_e = 1; s.wa_e = 7; s.ra2_d = 7;
        step("load_use", s, C_LU, 2'b00, 2'b00, 1'b0);

        s = '0; s.wa_m = 7; s.we_m = 1; s.ra2_e = 7; s.ra2_d = 7;
        step("after_load", s, FWD ? C_NONE : C_LU, 2'b00, FWD ? 2'b01 : 2'b00, 1'b0);

        s = '0; s.load_e = 1; s.we_e = 1; s.wa_e = 7; s.ra2_d = 7; s.br = 1;
        step("load_use_branch", s, C_BR, 2'b00, 2'b00, 1'b0);

        s = '0; s.load_e = 1; s.we_e = 1; s.we_m = 1; s.we_w = 1;
        step("x0_never", s, C_NONE, 2'b00, 2'b00, 1'b0);

        s = '0; s.we_e = 1; s.wa_e = 9; s.ra1_d = 9;
        step("alu_raw_e", s, FWD ? C_NONE : C_LU, 2'b00, 2'b00, 1'b0);
        s.we_e = 0;
        step("no_we_e", s, C_NONE, 2'b00, 2'b00, 1'b0);
        s = '0; s.we_w = 1; s.wa_w = 9; s.ra1_d = 9;
        step("w_match", s, C_NONE, 2'b00, 2'b00, 1'b0);

        s = '0; s.acc = 1; s.rdy = 0;
        for (int i = 0; i < 3; i++)
            step("mem_wait", s, C_MW, 2'b00, 2'b00, 1'b0);
        s.rdy = 1;
        step("mem_done", s, C_NONE, 2'b00, 2'b00, 1'b0);
        step("mem_ready_first", s, C_NONE, 2'b00, 2'b00, 1'b0);

        s = '0; s.acc = 1; s.br = 1; s.load_e = 1; s.we_e = 1; s.wa_e = 3; s.ra1_d = 3;
        step("mem_wait_over_br", s, C_MW, 2'b00, 2'b00, 1'b0);
        s = '0; s.acc = 1; s.rdy = 1;
        step("mem_done2", s, C_NONE, 2'b00, 2'b00, 1'b0);

        s = '0; s.acc = 1; s.rdy = 0;
        for (int i = 0; i < 4; i++)
            step("timeout_wait", s, C_MW, 2'b00, 2'b00, 1'b0);
        s = '0; s.br = 1;
        step("error_held", s, C_MW, 2'b00, 2'b00, 1'b1);
        s = '0; s.acc = 1; s.rdy = 1;
        step("error_ready", s, C_MW, 2'b00, 2'b00, 1'b1);

        // Asynchronous reset in the middle of a cycle clears everything at once
        #2;
        rst_n = 1'b0;
        exp_cnt = '0;
        #1;
        push_exp("async_reset", C_NONE, 2'b00, 2'b00, 1'b0);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;

        s = '0; s.acc = 1; s.rdy = 0;
        step("post_reset_wait", s, C_MW, 2'b00, 2'b00, 1'b0);
        s.rdy = 1;
        step("post_reset_done", s, C_NONE, 2'b00, 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
